// File: rtl/v810_pkg.sv
// Shared types and constants for the v810 external-bus controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package v810_pkg;

  // Bus-controller sequencer states.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } bctl_state_t;

  // Wait-state code meaning "wait for EXT_READYn" rather than a fixed count.
  localparam logic [2:0] BCTL_WS_EXT = 3'd7;

  // Bus status value that, with MRQn high, marks an I/O cycle.
  localparam logic [1:0] ST_IO = 2'b10;

  // Pick the 3-bit wait code of one region out of the packed per-region field.
  function automatic logic [2:0] region_ws(input logic [11:0] cfg, input logic [1:0] r);
    logic [2:0] code;
    case (r)
      2'd0:    code = cfg[2:0];
      2'd1:    code = cfg[5:3];
      2'd2:    code = cfg[8:6];
      default: code = cfg[11:9];
    endcase
    return code;
  endfunction

endpackage

// File: rtl/v810_bus_decode.sv
// Classifies a bus cycle as one of four memory regions or I/O space.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module v810_bus_decode
  import v810_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic        mrq_n_i,
  input  logic [1:0]  st_i,
  output logic [1:0]  region_o,
  output logic        io_o,
  output logic        vld_o
);

  // Only the top two address bits select a region.
  logic unused_addr;
  assign unused_addr = ^a_i[29:0];

  assign region_o = a_i[31:30];
  assign io_o     = mrq_n_i && (st_i == ST_IO);
  assign vld_o    = !mrq_n_i || io_o;

endmodule

// File: rtl/v810_bus_ctrl.sv
// External-bus sequencer: decodes BCYSTn cycles, counts per-region waits, drives READYn/SZRQn and strobes.
// Latency: strobes one cycle after BCYSTn, READYn low WS cycles later; back-to-back starts need no idle cycle.
// Backpressure: CE=0 freezes all state; optional BCTL_TIMEOUT_EN bounds code-7 waits on EXT_READYn.
module v810_bus_ctrl
  import v810_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [1:0]  ST,
  input  logic        DAn,
  input  logic        MRQn,
  input  logic        RW,
  input  logic        BCYSTn,
  input  logic [11:0] CFG_WS,
  input  logic [3:0]  CFG_W16,
  input  logic [2:0]  CFG_IO_WS,
  input  logic        EXT_READYn,
  output logic        READYn,
  output logic        SZRQn,
  output logic [3:0]  nCE,
  output logic        nIOCE,
  output logic        nOE,
  output logic        nWE,
  output logic        BUSY,
  output logic        ERR
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  bctl_state_t state_q, state_d;
  logic [1:0]  region_q, region_d;
  logic        io_q, io_d;
  logic        rw_q, rw_d;
  logic        w16_q, w16_d;
  logic        ext_q, ext_d;
  logic [2:0]  wcnt_q, wcnt_d;

  logic [1:0]  dec_region;
  logic        dec_io;
  logic        dec_vld;
  logic        start;
  logic [2:0]  start_code;
  logic        ready;
  logic        tmo_hit;

  v810_bus_decode u_decode (
    .a_i      (A),
    .mrq_n_i  (MRQn),
    .st_i     (ST),
    .region_o (dec_region),
    .io_o     (dec_io),
    .vld_o    (dec_vld)
  );

  assign start      = dec_vld && !BCYSTn;
  assign start_code = dec_io ? CFG_IO_WS : region_ws(CFG_WS, dec_region);

  // Ready when the fixed wait count has run out, or on external/forced ready for code 7.
  assign ready = (state_q == ACCESS) &&
                 (ext_q ? (!EXT_READYn || tmo_hit) : (wcnt_q == 3'd0));

`ifdef BCTL_TIMEOUT_EN
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  assign tmo_hit = ext_q && (tcnt_q == TW'(TIMEOUT));

  // Count unanswered cycles of a code-7 access; any other cycle restarts from zero.
  always_comb begin
    tcnt_d = '0;
    err_d  = err_q;
    if (state_q == ACCESS && ext_q && !ready && !DAn) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    if (state_q == ACCESS && tmo_hit && EXT_READYn) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge CLK) begin
    if (RES) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else if (CE) begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic [TW-1:0] unused_tmo;
  assign unused_tmo = TW'(TIMEOUT);
  assign tmo_hit    = 1'b0;
  assign ERR        = 1'b0;
`endif

  // Sequencer next state: latch a new access, count waits, complete or abort.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    io_d     = io_q;
    rw_d     = rw_q;
    w16_d    = w16_q;
    ext_d    = ext_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCESS;
          region_d = dec_region;
          io_d     = dec_io;
          rw_d     = RW;
          w16_d    = !dec_io && CFG_W16[dec_region];
          ext_d    = (start_code == BCTL_WS_EXT);
          wcnt_d   = (start_code == BCTL_WS_EXT) ? 3'd0 : start_code;
        end
      end
      ACCESS: begin
        if (ready) begin
          if (start) begin
            region_d = dec_region;
            io_d     = dec_io;
            rw_d     = RW;
            w16_d    = !dec_io && CFG_W16[dec_region];
            ext_d    = (start_code == BCTL_WS_EXT);
            wcnt_d   = (start_code == BCTL_WS_EXT) ? 3'd0 : start_code;
          end else begin
            state_d = IDLE;
          end
        end else if (DAn) begin
          state_d = IDLE;
        end else if (!ext_q) begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers advance only on clock enable; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= IDLE;
      region_q <= 2'd0;
      io_q     <= 1'b0;
      rw_q     <= 1'b0;
      w16_q    <= 1'b0;
      ext_q    <= 1'b0;
      wcnt_q   <= 3'd0;
    end else if (CE) begin
      state_q  <= state_d;
      region_q <= region_d;
      io_q     <= io_d;
      rw_q     <= rw_d;
      w16_q    <= w16_d;
      ext_q    <= ext_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Bus-side outputs come straight from the latched access, so strobes are glitch-free.
  always_comb begin
    BUSY   = 1'b0;
    nCE    = 4'hF;
    nIOCE  = 1'b1;
    nOE    = 1'b1;
    nWE    = 1'b1;
    READYn = 1'b1;
    SZRQn  = 1'b1;
    if (state_q == ACCESS) begin
      BUSY = 1'b1;
      if (io_q) begin
        nIOCE = 1'b0;
      end else begin
        nCE[region_q] = 1'b0;
      end
      nOE    = !rw_q;
      nWE    = rw_q;
      READYn = !ready;
      SZRQn  = !(ready && w16_q);
    end
  end

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Self-checking bench for v810_bus_ctrl: directed vector table, corner sequences, randomized accesses.
// Latency: n/a.
// Backpressure: random CE gaps exercise the hold behaviour.
module tb_v810_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RES, CE, DAn, MRQn, RW, BCYSTn, EXT_READYn;
  logic [31:0] A;
  logic [1:0]  ST;
  logic [11:0] CFG_WS;
  logic [3:0]  CFG_W16;
  logic [2:0]  CFG_IO_WS;
  logic        READYn, SZRQn, nIOCE, nOE, nWE, BUSY, ERR;
  logic [3:0]  nCE;

  always #5 CLK = ~CLK;

  v810_bus_ctrl #(.TIMEOUT(64)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .ST(ST), .DAn(DAn), .MRQn(MRQn),
    .RW(RW), .BCYSTn(BCYSTn), .CFG_WS(CFG_WS), .CFG_W16(CFG_W16),
    .CFG_IO_WS(CFG_IO_WS), .EXT_READYn(EXT_READYn), .READYn(READYn),
    .SZRQn(SZRQn), .nCE(nCE), .nIOCE(nIOCE), .nOE(nOE), .nWE(nWE),
    .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct {
    logic [31:0] a;
    logic        mrqn;
    logic [1:0]  st;
    logic        rw;
    logic [11:0] ws;
    logic [3:0]  w16;
    logic [2:0]  io_ws;
    logic [3:0]  exp_nce;
    logic        exp_nioce;
    int          rdy_cyc;
    logic        exp_szrqn;
  } vec_t;

  vec_t vec[5];
  int   n_chk = 0;
  int   n_pass = 0;

  // reference-model scratch for the random phase
  logic       io_m, rw_m, wide_m, rdy_m, done_m;
  logic [1:0] r_m;
  logic [3:0] nce_m;
  int         ws_m, en_m, guard;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_out(input string nm, input logic busy, input logic [3:0] nce,
                         input logic nioce, input logic noe, input logic nwe,
                         input logic readyn, input logic szrqn);
    chk({nm, ".BUSY"},   BUSY,   busy);
    chk({nm, ".nCE"},    nCE,    nce);
    chk({nm, ".nIOCE"},  nIOCE,  nioce);
    chk({nm, ".nOE"},    nOE,    noe);
    chk({nm, ".nWE"},    nWE,    nwe);
    chk({nm, ".READYn"}, READYn, readyn);
    chk({nm, ".SZRQn"},  SZRQn,  szrqn);
  endtask

  task automatic chk_idle(input string nm);
    chk_out(nm, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    //          a             mrqn  st     rw    ws       w16   io    nce      nioce rdy szrqn
    vec[0] = '{32'h8000_0000, 1'b0, 2'b00, 1'b1, 12'h000, 4'h0, 3'd0, 4'b1011, 1'b1, 1, 1'b1};
    vec[1] = '{32'h0000_0040, 1'b0, 2'b00, 1'b0, 12'h003, 4'h1, 3'd0, 4'b1110, 1'b1, 4, 1'b0};
    vec[2] = '{32'h0000_1000, 1'b1, 2'b10, 1'b1, 12'h000, 4'hF, 3'd1, 4'b1111, 1'b0, 2, 1'b1};
    vec[3] = '{32'hC000_1234, 1'b0, 2'b01, 1'b1, 12'hA00, 4'h8, 3'd0, 4'b0111, 1'b1, 6, 1'b0};
    vec[4] = '{32'h4000_0000, 1'b0, 2'b11, 1'b0, 12'h010, 4'h1, 3'd6, 4'b1101, 1'b1, 3, 1'b1};

    RES = 1'b1; CE = 1'b1; A = '0; ST = '0; DAn = 1'b1; MRQn = 1'b1; RW = 1'b1;
    BCYSTn = 1'b1; CFG_WS = '0; CFG_W16 = '0; CFG_IO_WS = '0; EXT_READYn = 1'b1;
    step(); step();
    chk_idle("reset");
    chk("reset.ERR", ERR, 1'b0);
    RES = 1'b0; DAn = 1'b0;
    step();

    // directed vector table
    for (int i = 0; i < 5; i++) begin
      CFG_WS = vec[i].ws; CFG_W16 = vec[i].w16; CFG_IO_WS = vec[i].io_ws;
      A = vec[i].a; MRQn = vec[i].mrqn; ST = vec[i].st; RW = vec[i].rw;
      BCYSTn = 1'b0;
      step();
      BCYSTn = 1'b1;
      settle();
      for (int c = 1; c <= vec[i].rdy_cyc; c++) begin
        chk_out($sformatf("vec%0d.c%0d", i, c), 1'b1, vec[i].exp_nce, vec[i].exp_nioce,
                !vec[i].rw, vec[i].rw,
                (c == vec[i].rdy_cyc) ? 1'b0 : 1'b1,
                (c == vec[i].rdy_cyc) ? vec[i].exp_szrqn : 1'b1);
        step();
      end
      chk_idle($sformatf("vec%0d.after", i));
    end

    // non-memory, non-I/O status is ignored
    MRQn = 1'b1; ST = 2'b00; BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1;
    settle();
    chk_idle("ignored_status");

    // back-to-back: new BCYSTn in the ready cycle of a zero-wait access
    CFG_WS = 12'h000; CFG_W16 = 4'h0;
    A = 32'h8000_0000; MRQn = 1'b0; ST = 2'b00; RW = 1'b1; BCYSTn = 1'b0;
    step();
    A = 32'h4000_0000; RW = 1'b0;
    settle();
    chk_out("b2b.c1", 1'b1, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    BCYSTn = 1'b1;
    settle();
    chk_out("b2b.c2", 1'b1, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_idle("b2b.end");

    // abort via DAn before ready: no READYn pulse, back to idle
    CFG_WS = 12'h005; A = 32'h0; RW = 1'b1; BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1;
    settle();
    chk_out("abort.c1", 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    DAn = 1'b1;
    step();
    chk_idle("abort.end");
    DAn = 1'b0;

    // code 7: READYn follows EXT_READYn, 16-bit region
    CFG_WS = 12'h007; CFG_W16 = 4'h1; RW = 1'b0; BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk_out($sformatf("ext.c%0d", c), 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
    end
    EXT_READYn = 1'b0;
    settle();
    chk_out("ext.rdy", 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    EXT_READYn = 1'b1;
    settle();
    chk_idle("ext.end");
    chk("ext.ERR", ERR, 1'b0);

    // code 7 with EXT_READYn held high
    CFG_W16 = 4'h0; RW = 1'b1; BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1;
`ifdef BCTL_TIMEOUT_EN
    for (int c = 1; c <= 64; c++) begin
      chk($sformatf("tmo.wait%0d.READYn", c), READYn, 1'b1);
      step();
    end
    chk("tmo.force.READYn", READYn, 1'b0);
    chk("tmo.force.ERR", ERR, 1'b0);
    step();
    chk("tmo.after.BUSY", BUSY, 1'b0);
    chk("tmo.after.ERR", ERR, 1'b1);
    BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1;
    step(); step();
    chk("tmo.sticky.ERR", ERR, 1'b1);
`else
    for (int c = 1; c <= 80; c++) begin
      chk($sformatf("nowait%0d.READYn", c), READYn, 1'b1);
      step();
    end
    chk("nowait.BUSY", BUSY, 1'b1);
    chk("nowait.ERR", ERR, 1'b0);
`endif
    // reset in the middle of an access
    RES = 1'b1;
    step();
    chk_idle("res_mid");
    chk("res_mid.ERR", ERR, 1'b0);
    RES = 1'b0;
    step();

    // randomized accesses against a transaction-level model
    for (int t = 0; t < 40; t++) begin
      io_m = ($urandom_range(0, 3) == 0);
      A = $urandom;
      RW = 1'($urandom_range(0, 1));
      MRQn = io_m;
      ST = io_m ? 2'b10 : 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) CFG_WS[3*j +: 3] = 3'($urandom_range(0, 6));
      CFG_W16 = 4'($urandom);
      CFG_IO_WS = 3'($urandom_range(0, 6));
      r_m = A[31:30];
      rw_m = RW;
      ws_m = io_m ? int'(CFG_IO_WS) : int'(CFG_WS[3*r_m +: 3]);
      wide_m = !io_m && CFG_W16[r_m];
      nce_m = io_m ? 4'hF : ~(4'b0001 << r_m);
      CE = 1'b1; BCYSTn = 1'b0;
      step();
      BCYSTn = 1'b1;
      CFG_WS = 12'($urandom); CFG_W16 = 4'($urandom); CFG_IO_WS = 3'($urandom);
      A = $urandom; RW = 1'($urandom_range(0, 1));
      en_m = 0; done_m = 1'b0; guard = 0;
      while (!done_m && guard < 100) begin
        CE = ($urandom_range(0, 3) != 0);
        settle();
        rdy_m = (en_m == ws_m);
        chk_out($sformatf("rnd%0d.c%0d", t, guard), 1'b1, nce_m, io_m ? 1'b0 : 1'b1,
                !rw_m, rw_m, rdy_m ? 1'b0 : 1'b1, (rdy_m && wide_m) ? 1'b0 : 1'b1);
        if (CE) begin
          if (rdy_m) done_m = 1'b1;
          else en_m++;
        end
        guard++;
        step();
      end
      chk($sformatf("rnd%0d.done", t), done_m, 1'b1);
      CE = 1'b1;
      settle();
      chk_idle($sformatf("rnd%0d.after", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
